// File: rtl/dec_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dec_pkg
// Brief   : Shared state encodings and helpers for the scanning decoders.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package dec_pkg;

   // Widest address the shared one-hot helper supports.
   localparam int DEC_MAX_N = 8;

   localparam logic [1:0] c_ST_IDLE   = 2'd0;
   localparam logic [1:0] c_ST_DIRECT = 2'd1;
   localparam logic [1:0] c_ST_SCAN   = 2'd2;

   function automatic int cnt_width(input int depth);
      return (depth <= 1) ? 1 : $clog2(depth);
   endfunction

   function automatic logic [(1<<DEC_MAX_N)-1:0] onehot(input logic [DEC_MAX_N-1:0] sel);
      logic [(1<<DEC_MAX_N)-1:0] v;
      v      = '0;
      v[sel] = 1'b1;
      return v;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dwell_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : dwell_timer
// Brief   : Prescaler that ticks on the last of every DWELL running cycles.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module dwell_timer
   import dec_pkg::*;
#(
   parameter int DWELL = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_run,
   input  logic i_clr,
   output logic o_tick
);

   localparam int               c_CW   = cnt_width(DWELL);
   localparam logic [c_CW-1:0]  c_LAST = c_CW'(DWELL - 1);

   logic [c_CW-1:0] r_cnt;

   // Holding run low freezes the count, so a paused scan resumes mid-dwell.
   assign o_tick = i_run && (r_cnt == c_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (i_clr || o_tick) begin
         r_cnt <= '0;
      end else if (i_run) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: rtl/decoder_scan_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : decoder_scan_n
// Brief   : Registered N-to-2^N one-hot decoder with enable and auto-scan.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module decoder_scan_n
   import dec_pkg::*;
#(
   parameter int N          = 3,
   parameter int DWELL      = 4,
   parameter bit ACTIVE_LOW = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_en,
   input  logic             i_mode,
   input  logic [N-1:0]     i_a,
   output logic [(1<<N)-1:0] o_d,
   output logic [N-1:0]     o_idx,
   output logic             o_wrap
);

   localparam int              c_W   = 1 << N;
   localparam logic [c_W-1:0]  c_POL = {c_W{ACTIVE_LOW}};

   logic [1:0]           r_state;
   logic [1:0]           w_state_nxt;
   logic [N-1:0]         r_idx;
   logic [N-1:0]         w_idx_nxt;
   logic [c_W-1:0]       r_d;
   logic [c_W-1:0]       w_onehot;
   logic                 r_wrap;
   logic                 w_wrap_nxt;
   logic                 w_tick;
   logic [DEC_MAX_N-1:0] w_sel_ext;

   // The action taken on an edge follows the inputs seen at that edge.
   always_comb begin
      if (!i_en) begin
         w_state_nxt = c_ST_IDLE;
      end else if (i_mode) begin
         w_state_nxt = c_ST_SCAN;
      end else begin
         w_state_nxt = c_ST_DIRECT;
      end
   end

   dwell_timer #(
      .DWELL (DWELL)
   ) u_dwell (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_run  (w_state_nxt == c_ST_SCAN),
      .i_clr  (w_state_nxt == c_ST_DIRECT),
      .o_tick (w_tick)
   );

   always_comb begin
      w_idx_nxt = r_idx;
      case (w_state_nxt)
         c_ST_DIRECT: w_idx_nxt = i_a;
         c_ST_SCAN:   if (w_tick) w_idx_nxt = r_idx + 1'b1;
         default:     w_idx_nxt = r_idx;
      endcase
   end

   assign w_wrap_nxt = w_tick && (r_idx == {N{1'b1}});

   always_comb begin
      w_sel_ext         = '0;
      w_sel_ext[N-1:0]  = w_idx_nxt;
   end

   assign w_onehot = c_W'(onehot(w_sel_ext));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_ST_IDLE;
         r_idx   <= '0;
         r_d     <= '0;
         r_wrap  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
         r_d     <= (w_state_nxt == c_ST_IDLE) ? '0 : w_onehot;
         r_wrap  <= w_wrap_nxt;
      end
   end

   // Polarity is applied after the register so reset yields the inactive level.
   assign o_d    = r_d ^ c_POL;
   assign o_idx  = r_idx;
   assign o_wrap = r_wrap;

   always @(posedge clk) begin
      if (rst_n && (r_state != c_ST_IDLE)) assert ($onehot(r_d));
   end

endmodule
`default_nettype wire

// File: tb/tb_decoder_scan_n.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : tb_decoder_scan_n
// Brief   : Directed bench for decoder_scan_n (N=3/DWELL=4 and N=2/DWELL=1/active-low).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_decoder_scan_n;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en, mode;
   logic [2:0] a;
   logic [7:0] d;
   logic [2:0] idx;
   logic       wrap;
   logic       en2, mode2;
   logic [1:0] a2;
   logic [3:0] d2;
   logic [1:0] idx2;
   logic       wrap2;

   int n_pass  = 0;
   int n_total = 0;

   logic [7:0] exp_d  [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
   logic [3:0] exp_d2 [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   always #5 clk = ~clk;

   decoder_scan_n #(.N(3), .DWELL(4), .ACTIVE_LOW(1'b0)) u_dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en),
      .i_mode (mode),
      .i_a    (a),
      .o_d    (d),
      .o_idx  (idx),
      .o_wrap (wrap)
   );

   decoder_scan_n #(.N(2), .DWELL(1), .ACTIVE_LOW(1'b1)) u_dut_corner (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_en   (en2),
      .i_mode (mode2),
      .i_a    (a2),
      .o_d    (d2),
      .o_idx  (idx2),
      .o_wrap (wrap2)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b1; en = 1'b0; mode = 1'b0; a = 3'd0;
      en2 = 1'b0; mode2 = 1'b0; a2 = 2'd0;
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      n_total++;
      if ({d, idx, wrap} !== {8'h00, 3'd0, 1'b0})
         $display("FAIL reset_main: got d=%h idx=%0d wrap=%b expected d=00 idx=0 wrap=0", d, idx, wrap);
      else n_pass++;
      n_total++;
      if ({d2, idx2, wrap2} !== {4'hF, 2'd0, 1'b0})
         $display("FAIL reset_corner: got d=%b idx=%0d wrap=%b expected d=1111 idx=0 wrap=0", d2, idx2, wrap2);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      step(); step();
      n_total++;
      if ({d, idx, wrap} !== {8'h00, 3'd0, 1'b0})
         $display("FAIL idle_after_reset: got d=%h idx=%0d wrap=%b expected d=00 idx=0 wrap=0", d, idx, wrap);
      else n_pass++;
   endtask

   task automatic test_direct();
      en = 1'b1; mode = 1'b0;
      for (int i = 0; i < 8; i++) begin
         a = 3'(i);
         step();
         n_total++;
         if ({d, idx, wrap} !== {exp_d[i], 3'(i), 1'b0})
            $display("FAIL direct_%0d: got d=%h idx=%0d wrap=%b expected d=%h idx=%0d wrap=0", i, d, idx, wrap, exp_d[i], i);
         else n_pass++;
      end
      en = 1'b0; a = 3'b110;
      step();
      n_total++;
      if ({d, idx, wrap} !== {8'h00, 3'd7, 1'b0})
         $display("FAIL direct_disabled: got d=%h idx=%0d wrap=%b expected d=00 idx=7 wrap=0", d, idx, wrap);
      else n_pass++;
   endtask

   task automatic test_scan();
      logic [2:0] e_idx;
      logic       e_wrap;
      int         wraps;
      wraps = 0;
      en = 1'b1; mode = 1'b1;
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      for (int c = 1; c <= 64; c++) begin
         step();
         e_idx  = 3'((c / 4) % 8);
         e_wrap = (c % 32 == 0);
         if (wrap) wraps++;
         n_total++;
         if ({d, idx, wrap} !== {exp_d[e_idx], e_idx, e_wrap})
            $display("FAIL scan_c%0d: got d=%h idx=%0d wrap=%b expected d=%h idx=%0d wrap=%b", c, d, idx, wrap, exp_d[e_idx], e_idx, e_wrap);
         else n_pass++;
      end
      n_total++;
      if (wraps !== 2) $display("FAIL scan_wrap_count: got %0d expected 2", wraps);
      else n_pass++;
   endtask

   task automatic test_pause();
      repeat (22) step();
      n_total++;
      if ({d, idx} !== {8'h20, 3'd5}) $display("FAIL pause_setup: got d=%h idx=%0d expected d=20 idx=5", d, idx);
      else n_pass++;
      en = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         n_total++;
         if ({d, idx, wrap} !== {8'h00, 3'd5, 1'b0})
            $display("FAIL pause_hold_%0d: got d=%h idx=%0d wrap=%b expected d=00 idx=5 wrap=0", i, d, idx, wrap);
         else n_pass++;
      end
      en = 1'b1;
      step();
      n_total++;
      if ({d, idx} !== {8'h20, 3'd5}) $display("FAIL pause_resume1: got d=%h idx=%0d expected d=20 idx=5", d, idx);
      else n_pass++;
      step();
      n_total++;
      if ({d, idx} !== {8'h40, 3'd6}) $display("FAIL pause_resume2: got d=%h idx=%0d expected d=40 idx=6", d, idx);
      else n_pass++;
      // Drop enable exactly on the edge that would advance.
      repeat (3) step();
      en = 1'b0;
      repeat (2) step();
      n_total++;
      if ({d, idx, wrap} !== {8'h00, 3'd6, 1'b0})
         $display("FAIL en_vs_tick_hold: got d=%h idx=%0d wrap=%b expected d=00 idx=6 wrap=0", d, idx, wrap);
      else n_pass++;
      en = 1'b1;
      step();
      n_total++;
      if ({d, idx, wrap} !== {8'h80, 3'd7, 1'b0})
         $display("FAIL en_vs_tick_advance: got d=%h idx=%0d wrap=%b expected d=80 idx=7 wrap=0", d, idx, wrap);
      else n_pass++;
   endtask

   task automatic test_mode_switch();
      en = 1'b1; mode = 1'b0; a = 3'd6;
      step();
      n_total++;
      if ({d, idx} !== {8'h40, 3'd6}) $display("FAIL sw_direct6: got d=%h idx=%0d expected d=40 idx=6", d, idx);
      else n_pass++;
      mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         n_total++;
         if ({d, idx, wrap} !== {8'h40, 3'd6, 1'b0})
            $display("FAIL sw_scan_dwell_%0d: got d=%h idx=%0d wrap=%b expected d=40 idx=6 wrap=0", i, d, idx, wrap);
         else n_pass++;
      end
      step();
      n_total++;
      if ({d, idx} !== {8'h80, 3'd7}) $display("FAIL sw_scan_adv: got d=%h idx=%0d expected d=80 idx=7", d, idx);
      else n_pass++;
      step();
      mode = 1'b0; a = 3'd2;
      for (int i = 0; i < 5; i++) begin
         step();
         n_total++;
         if ({d, idx, wrap} !== {8'h04, 3'd2, 1'b0})
            $display("FAIL sw_to_direct_%0d: got d=%h idx=%0d wrap=%b expected d=04 idx=2 wrap=0", i, d, idx, wrap);
         else n_pass++;
      end
   endtask

   task automatic test_reset_mid_scan();
      mode = 1'b1;
      repeat (5) step();
      #2 rst_n = 1'b0;
      #1;
      n_total++;
      if ({d, idx, wrap} !== {8'h00, 3'd0, 1'b0})
         $display("FAIL reset_mid_scan: got d=%h idx=%0d wrap=%b expected d=00 idx=0 wrap=0", d, idx, wrap);
      else n_pass++;
      @(negedge clk) rst_n = 1'b1;
      repeat (3) step();
      n_total++;
      if ({d, idx, wrap} !== {8'h01, 3'd0, 1'b0})
         $display("FAIL rescan_dwell: got d=%h idx=%0d wrap=%b expected d=01 idx=0 wrap=0", d, idx, wrap);
      else n_pass++;
      step();
      n_total++;
      if ({d, idx} !== {8'h02, 3'd1}) $display("FAIL rescan_adv: got d=%h idx=%0d expected d=02 idx=1", d, idx);
      else n_pass++;
      en = 1'b0;
   endtask

   task automatic test_corner();
      int k;
      en2 = 1'b1; mode2 = 1'b1;
      for (int c = 1; c <= 12; c++) begin
         step();
         k = c % 4;
         n_total++;
         if ({d2, idx2, wrap2} !== {exp_d2[k], 2'(k), (k == 0)})
            $display("FAIL corner_c%0d: got d=%b idx=%0d wrap=%b expected d=%b idx=%0d wrap=%b", c, d2, idx2, wrap2, exp_d2[k], k, (k == 0));
         else n_pass++;
      end
      mode2 = 1'b0; a2 = 2'd2;
      step();
      n_total++;
      if ({d2, idx2, wrap2} !== {4'b1011, 2'd2, 1'b0})
         $display("FAIL corner_direct: got d=%b idx=%0d wrap=%b expected d=1011 idx=2 wrap=0", d2, idx2, wrap2);
      else n_pass++;
      en2 = 1'b0;
      step();
      n_total++;
      if (d2 !== 4'b1111) $display("FAIL corner_idle: got d=%b expected d=1111", d2);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_direct();
      test_scan();
      test_pause();
      test_mode_switch();
      test_reset_mid_scan();
      test_corner();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/decoder_scan_n.md
Name: decoder_scan_n

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with enable and a built-in auto-scan mode.
- Direct mode: latches the decoded value of input `a` every clock.
- Scan mode: steps an internal index through every output in turn, dwelling DWELL cycles on each, with a wrap pulse at the end of each sweep.
- Drives display-digit multiplexing, row strobes and chip-select fan-out in the datapath.

Parameters:
- N, 3, address width; output width is 2^N.
- DWELL, 4, cycles spent on each index in scan mode; legal range 1..65535.
- ACTIVE_LOW, 0, 1 inverts every bit of d, so inactive = 1 and selected = 0.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  enable; 0 blanks d and pauses all counters.
- mode  input  1  0 = direct decode of a, 1 = auto-scan.
- a  input  N  address for direct mode; ignored in scan mode.
- d  output  2^N  registered one-hot select (polarity set by ACTIVE_LOW).
- idx  output  N  registered index currently driven on d.
- wrap  output  1  one-cycle pulse when the scan index wraps from 2^N-1 to 0.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values, asserted immediately and independent of clk:
  - d = all-0 (all-1 if ACTIVE_LOW).
  - idx = 0, wrap = 0, dwell counter = 0, FSM = IDLE.
- Reset deassertion: first state update on the next rising clk edge.
- FSM states: IDLE, DIRECT, SCAN. Evaluated each edge:
  - en=0 -> IDLE.
  - en=1, mode=0 -> DIRECT.
  - en=1, mode=1 -> SCAN.
- IDLE:
  - d = inactive; idx and dwell counter hold; wrap = 0.
  - Re-enabling resumes from the held idx and dwell count (pause, not restart).
- DIRECT:
  - Each edge: idx <= a, d <= onehot(a). Latency is 1 cycle from a to d.
  - Dwell counter cleared; wrap = 0.
- SCAN:
  - d = onehot(idx) every cycle.
  - Dwell counter increments each cycle.
  - When dwell = DWELL-1: dwell <= 0 and idx <= idx+1, modulo 2^N.
  - wrap is registered and asserts for exactly one cycle, the same cycle d first shows index 0 after 2^N-1.
  - DWELL=1: idx advances every cycle and wrap fires every 2^N cycles.
- Mode switch DIRECT->SCAN:
  - Scan starts from the current idx (last latched a), dwell = 0.
  - First advance occurs DWELL cycles later.
- Mode switch SCAN->DIRECT:
  - Next edge loads a; dwell cleared; no wrap pulse generated.
- Simultaneous events:
  - en falling on the same edge as a scheduled advance: en wins; idx holds and dwell holds at DWELL-1.
  - The advance then occurs on the first enabled SCAN edge.
- Reset mid-scan: all state zeroed asynchronously; no partial pulse on wrap.
- Output invariant: d is exactly one-hot (or one-cold) whenever the FSM is not IDLE; never multi-hot.
- Width rules:
  - Dwell counter width = clog2(DWELL), minimum 1 bit.
  - idx arithmetic is unsigned N-bit with natural wrap.

Decomposition:
- Shared package dec_pkg holds:
  - state enum {IDLE, DIRECT, SCAN};
  - function onehot(N-bit) returning 2^N bits;
  - localparam helper for counter width (clog2 with minimum 1).
- One sub-module: dwell_timer (parameter DWELL; inputs clk, rst_n, run, clr; output tick). Isolates the prescaler from the FSM and is reused by other scan blocks.
- Polarity inversion is a single output XOR in the top level.

Test Plan:
- Reset/IDLE: rst_n=0 mid-cycle -> d=8'h00, idx=0, wrap=0 immediately. Release with en=0 -> d stays 8'h00.
- DIRECT: en=1, mode=0, a=0..7 applied one per cycle -> d=8'h01,02,04,...,80, each one cycle after its a. en=0 with a=3'b110 -> d=8'h00.
- SCAN, N=3, DWELL=4: from reset, en=1, mode=1 -> idx stays 0 for 4 cycles, then 1, 2, ... 7.
  - After 32 cycles: idx=0, d=8'h01, wrap=1 for exactly one cycle.
  - Second wrap 32 cycles later.
- Pause: in SCAN at idx=5, dwell=2, drop en for 10 cycles -> d=8'h00, idx=5. Re-enable -> idx=6 after 2 more cycles.
- Mode switch: DIRECT with a=6, switch to SCAN -> d=8'h40 for 4 cycles, then 8'h80.
  - At index 7, switch mid-dwell to DIRECT with a=2 -> d=8'h04 next cycle, wrap never asserts.
- Corner params: N=2, DWELL=1, ACTIVE_LOW=1 -> d cycles 4'b1110, 1101, 1011, 0111 each cycle; wrap every 4th cycle; reset value d=4'b1111.
